// File: rtl/bcd_game_timer.sv
// bcd_game_timer: prescaled N-digit BCD up/down timer.
// It supports pause, clear, preset load and lap capture.
// It also raises a wrap pulse and a sticky expiry flag.
module bcd_game_timer #(
    parameter int unsigned TICK_DIV = 5000000,
    parameter int unsigned DIGITS   = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Enable,
    input  logic                  i_Clear,
    input  logic                  i_Mode,
    input  logic                  i_Load,
    input  logic [4*DIGITS-1:0]   i_LoadVal,
    input  logic                  i_Lap,
    output logic [4*DIGITS-1:0]   o_Digits,
    output logic [4*DIGITS-1:0]   o_Lap,
    output logic                  o_Tick,
    output logic                  o_Wrap,
    output logic                  o_Expired
);

    localparam int unsigned W  = 4 * DIGITS;
    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0]   r_Presc;
    logic [PW-1:0]   w_presc_nxt;
    logic            w_tick;
    logic [W-1:0]    w_up;
    logic [W-1:0]    w_dn;
    logic [W-1:0]    w_load_san;
    logic [DIGITS:0] w_carry;
    logic [DIGITS:0] w_borrow;
    logic [W-1:0]    w_digits_nxt;
    logic            w_tick_nxt;
    logic            w_wrap_nxt;
    logic            w_expired_nxt;

    assign w_tick = i_Enable && (r_Presc == P_LAST);

    // Per-digit increment/decrement chains and load sanitising
    always_comb begin
        logic [3:0] v_d;
        logic [3:0] v_l;
        w_up        = '0;
        w_dn        = '0;
        w_load_san  = '0;
        w_carry     = '0;
        w_borrow    = '0;
        w_carry[0]  = 1'b1;
        w_borrow[0] = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            v_d = o_Digits[4*k +: 4];
            v_l = i_LoadVal[4*k +: 4];
            w_up[4*k +: 4] = w_carry[k]  ? ((v_d == 4'd9) ? 4'd0 : 4'(v_d + 4'd1)) : v_d;
            w_dn[4*k +: 4] = w_borrow[k] ? ((v_d == 4'd0) ? 4'd9 : 4'(v_d - 4'd1)) : v_d;
            w_carry[k+1]   = w_carry[k]  && (v_d == 4'd9);
            w_borrow[k+1]  = w_borrow[k] && (v_d == 4'd0);
            w_load_san[4*k +: 4] = (v_l > 4'd9) ? 4'd9 : v_l;
        end
    end

    // Next-state selection: clear beats load beats tick
    always_comb begin
        w_presc_nxt   = r_Presc;
        w_digits_nxt  = o_Digits;
        w_tick_nxt    = 1'b0;
        w_wrap_nxt    = 1'b0;
        w_expired_nxt = o_Expired;
        if (i_Enable) begin
            w_presc_nxt = (r_Presc == P_LAST) ? '0 : PW'(r_Presc + 1'b1);
        end
        if (i_Clear) begin
            w_presc_nxt   = '0;
            w_digits_nxt  = '0;
            w_expired_nxt = 1'b0;
        end else if (i_Load) begin
            w_presc_nxt   = '0;
            w_digits_nxt  = w_load_san;
            w_expired_nxt = i_Mode && (i_LoadVal == '0);
        end else if (w_tick) begin
            if (i_Mode) begin
                // An already-expired or already-zero count never borrows below zero
                if (!o_Expired) begin
                    if (w_borrow[DIGITS]) begin
                        w_expired_nxt = 1'b1;
                    end else begin
                        w_digits_nxt  = w_dn;
                        w_tick_nxt    = 1'b1;
                        w_expired_nxt = (w_dn == '0);
                    end
                end
            end else begin
                w_digits_nxt = w_up;
                w_tick_nxt   = 1'b1;
                w_wrap_nxt   = w_carry[DIGITS];
            end
        end
    end

    // State and output registers
    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            r_Presc   <= '0;
            o_Digits  <= '0;
            o_Lap     <= '0;
            o_Tick    <= 1'b0;
            o_Wrap    <= 1'b0;
            o_Expired <= 1'b0;
        end else begin
            r_Presc   <= w_presc_nxt;
            o_Digits  <= w_digits_nxt;
            o_Tick    <= w_tick_nxt;
            o_Wrap    <= w_wrap_nxt;
            o_Expired <= w_expired_nxt;
            if (i_Lap) begin
                o_Lap <= o_Digits;
            end
        end
    end

endmodule

// File: tb/tb_bcd_game_timer.sv
// Directed bench for bcd_game_timer with TICK_DIV=4 and DIGITS=2.
module tb_bcd_game_timer;

    logic       i_Clk = 1'b0;
    logic       i_Rst;
    logic       i_Enable;
    logic       i_Clear;
    logic       i_Mode;
    logic       i_Load;
    logic [7:0] i_LoadVal;
    logic       i_Lap;
    logic [7:0] o_Digits;
    logic [7:0] o_Lap;
    logic       o_Tick;
    logic       o_Wrap;
    logic       o_Expired;

    int checks = 0;
    int errors = 0;

    bcd_game_timer #(.TICK_DIV(4), .DIGITS(2)) dut (
        .i_Clk(i_Clk), .i_Rst(i_Rst), .i_Enable(i_Enable), .i_Clear(i_Clear),
        .i_Mode(i_Mode), .i_Load(i_Load), .i_LoadVal(i_LoadVal), .i_Lap(i_Lap),
        .o_Digits(o_Digits), .o_Lap(o_Lap), .o_Tick(o_Tick), .o_Wrap(o_Wrap),
        .o_Expired(o_Expired)
    );

    always #5 i_Clk = ~i_Clk;

    // Advance n rising edges and settle 1 time unit past the last one
    task automatic step(input int n);
        repeat (n) @(posedge i_Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] val);
        i_Load = 1'b1; i_LoadVal = val;
        step(1);
        i_Load = 1'b0;
    endtask

    initial begin
        i_Rst = 1'b0; i_Enable = 1'b0; i_Clear = 1'b0; i_Mode = 1'b0;
        i_Load = 1'b0; i_LoadVal = 8'h00; i_Lap = 1'b0;
        step(2);
        chk("rst_digits", o_Digits, 8'h00);
        chk("rst_lap", o_Lap, 8'h00);
        chk("rst_flags", {5'd0, o_Tick, o_Wrap, o_Expired}, 8'h00);

        // Up counting from reset
        i_Rst = 1'b1; i_Enable = 1'b1;
        step(3);
        chk("up_pre_tick", {3'd0, o_Tick, o_Digits[3:0]}, 8'h00);
        step(1);
        chk("up_01", o_Digits, 8'h01);
        chk("up_tick1", {7'd0, o_Tick}, 8'h01);
        step(1);
        chk("up_tick_pulse", {7'd0, o_Tick}, 8'h00);
        step(3);
        chk("up_02", o_Digits, 8'h02);
        chk("up_tick2", {7'd0, o_Tick}, 8'h01);

        // Wrap 98 -> 99 -> 00
        do_load(8'h98);
        chk("load_98", o_Digits, 8'h98);
        chk("load_no_tick", {7'd0, o_Tick}, 8'h00);
        step(4);
        chk("wrap_99", o_Digits, 8'h99);
        chk("wrap_not_yet", {7'd0, o_Wrap}, 8'h00);
        step(4);
        chk("wrap_00", o_Digits, 8'h00);
        chk("wrap_flag", {6'd0, o_Wrap, o_Tick}, 8'h03);
        step(1);
        chk("wrap_pulse_end", {7'd0, o_Wrap}, 8'h00);

        // Down borrow across digits
        i_Mode = 1'b1;
        do_load(8'h10);
        step(4);
        chk("down_borrow_09", o_Digits, 8'h09);

        // Countdown to expiry
        do_load(8'h02);
        chk("down_load_02", {o_Digits[6:0], o_Expired}, {8'h02 << 1} | 8'h00);
        step(4);
        chk("down_01", o_Digits, 8'h01);
        step(4);
        chk("down_00", o_Digits, 8'h00);
        chk("expired_set", {6'd0, o_Expired, o_Tick}, 8'h03);
        for (int i = 0; i < 8; i++) begin
            step(1);
            chk("expired_hold", {o_Tick, o_Expired, o_Digits[5:0]}, 8'h40);
        end

        // Pause holds count and prescaler
        i_Mode = 1'b0;
        do_load(8'h12);
        chk("load_clears_expired", {7'd0, o_Expired}, 8'h00);
        step(4);
        chk("pause_13", o_Digits, 8'h13);
        step(2);
        i_Enable = 1'b0;
        step(10);
        chk("paused_digits", o_Digits, 8'h13);
        chk("paused_tick", {7'd0, o_Tick}, 8'h00);
        i_Enable = 1'b1;
        step(1);
        chk("resume_early", o_Digits, 8'h13);
        step(1);
        chk("resume_14", o_Digits, 8'h14);
        chk("resume_tick", {7'd0, o_Tick}, 8'h01);

        // Lap coincident with 09 -> 10 tick
        do_load(8'h08);
        step(4);
        chk("lap_pre_09", o_Digits, 8'h09);
        step(3);
        i_Lap = 1'b1;
        step(1);
        i_Lap = 1'b0;
        chk("lap_digits_10", o_Digits, 8'h10);
        chk("lap_value_09", o_Lap, 8'h09);

        // Clear wins over load; lap untouched
        i_Clear = 1'b1; i_Load = 1'b1; i_LoadVal = 8'h55;
        step(1);
        i_Clear = 1'b0; i_Load = 1'b0;
        chk("clear_over_load", o_Digits, 8'h00);
        chk("clear_keeps_lap", o_Lap, 8'h09);

        // Load of zero while counting down expires immediately; clear drops it
        i_Mode = 1'b1;
        do_load(8'h00);
        chk("load0_expired", {7'd0, o_Expired}, 8'h01);
        i_Clear = 1'b1;
        step(1);
        i_Clear = 1'b0;
        chk("clear_expired", {7'd0, o_Expired}, 8'h00);

        // Load sanitising and async reset
        i_Mode = 1'b0;
        do_load(8'hAB);
        chk("sanitize_AB", o_Digits, 8'h99);
        do_load(8'hF3);
        chk("sanitize_F3", o_Digits, 8'h93);
        step(2);
        #2;
        i_Rst = 1'b0;
        #1;
        chk("async_rst_digits", o_Digits, 8'h00);
        chk("async_rst_lap", o_Lap, 8'h00);
        chk("async_rst_flags", {5'd0, o_Tick, o_Wrap, o_Expired}, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
